// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU MEM stage and a
// DMA/debug port. Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE. When both
// ports request at once, round-robin arbitration picks the winner. The CPU is told to
// stall while its request is still outstanding.
//
// Ports:
//   clk_i, rst_i               clock; synchronous active-low reset
//   cpu_req_i/we/addr/wdata    CPU request, held stable until cpu_done_o
//   cpu_rdata_o, cpu_done_o    CPU read data (sticky) and one-cycle completion pulse
//   cpu_stall_o                cpu_req_i & ~cpu_done_o
//   dma_*                      same protocol as the CPU port
//   mem_en_o/we/addr/wdata     memory strobe and latched request fields
//   mem_rdata_i                memory read data, sampled on the last ACCESS cycle
//   conflict_cnt_o             saturating count of IDLE cycles with both requests high
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_done_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_done_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;            // 0 = CPU, 1 = DMA
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LAT_W-1:0]  wait_q, wait_d;
    logic              first_q, first_d;        // marks the single mem_en_o cycle
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;
    logic              sel_dma;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        first_d     = first_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        conflict_d  = conflict_q;
        sel_dma     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_i || dma_req_i) begin
                    if (cpu_req_i && dma_req_i) begin
                        // Tie goes to whichever port was not served last.
                        sel_dma = ~last_gnt_q;
                        if (conflict_q != {CNT_W{1'b1}}) begin
                            conflict_d = conflict_q + 1'b1;
                        end
                    end else begin
                        sel_dma = dma_req_i;
                    end
                    gnt_d      = sel_dma;
                    last_gnt_d = sel_dma;
                    we_d       = sel_dma ? dma_we_i    : cpu_we_i;
                    addr_d     = sel_dma ? dma_addr_i  : cpu_addr_i;
                    wdata_d    = sel_dma ? dma_wdata_i : cpu_wdata_i;
                    wait_d     = LAT_W'(MEM_LAT);
                    first_d    = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                first_d = 1'b0;
                wait_d  = wait_q - 1'b1;
                if (wait_q == LAT_W'(1)) begin
                    if (!we_q) begin
                        if (gnt_q) begin
                            dma_rdata_d = mem_rdata_i;
                        end else begin
                            cpu_rdata_d = mem_rdata_i;
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            first_q     <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            conflict_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            first_q     <= first_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            conflict_q  <= conflict_d;
        end
    end

    // Pulses are masked by rst_i so a reset landing on DONE never shows a completion.
    always_comb begin
        mem_en_o       = rst_i && (state_q == ACCESS) && first_q;
        mem_we_o       = mem_en_o && we_q;
        mem_addr_o     = addr_q;
        mem_wdata_o    = wdata_q;
        cpu_done_o     = rst_i && (state_q == DONE) && !gnt_q;
        dma_done_o     = rst_i && (state_q == DONE) && gnt_q;
        cpu_rdata_o    = cpu_rdata_q;
        dma_rdata_o    = dma_rdata_q;
        cpu_stall_o    = cpu_req_i && !cpu_done_o;
        conflict_cnt_o = conflict_q;
    end

endmodule
